fifo_flex: RTL

//   Parametrised synchronous FIFO, successor to the basic 8x32 buffer. Adds arbitrary
//   (non-power-of-2) depth, optional first-word-fall-through (FWFT) read mode, programmable

---
 rtl/fifo_flex.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through read,
// programmable almost flags, occupancy output and sticky overflow/underflow errors.
module fifo_flex #(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 32,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 28,
   parameter int AEMPTY_THRESH = 4,
   parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
   parameter int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  level,
   input  logic                  clr_err,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0]  level_q;
   logic                  rd_ok, wr_ok;

   assign level        = level_q;
   assign empty        = (level_q == '0);
   assign full         = (level_q == CNT_WIDTH'(FIFO_DEPTH));
   assign almost_full  = (level_q >= CNT_WIDTH'(AFULL_THRESH));
   assign almost_empty = (level_q <= CNT_WIDTH'(AEMPTY_THRESH));

   // A full FIFO still accepts a write when the same cycle pops the head.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[wr_ptr] <= din;
   end

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
         if (rd_ok)
            rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
         if (wr_ok && !rd_ok)
            level_q <= level_q + 1'b1;
         else if (rd_ok && !wr_ok)
            level_q <= level_q - 1'b1;
      end
   end

   // A new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_ok)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (rd_en && empty)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = mem[rd_ptr];
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (rst)
               dout_q <= '0;
            else if (rd_ok)
               dout_q <= mem[rd_ptr];
         end
         assign dout = dout_q;
      end
   endgenerate

endmodule
